// File: rtl/quad_pkg.sv
// Shared register map, status bit positions and quadrature step decoding
// for the quadrature encoder receiver.
package quad_pkg;

  localparam logic [1:0] ADDR_POS     = 2'd0;
  localparam logic [1:0] ADDR_VEL     = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_PRELOAD = 2'd3;

  localparam int STATUS_ERR_BIT = 0;
  localparam int STATUS_DIR_BIT = 1;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  // Position of an {A,B} pair along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_t decode_step(input logic [1:0] old_ab, input logic [1:0] new_ab);
    logic [1:0] diff;
    diff = phase_of(new_ab) - phase_of(old_ab);
    case (diff)
      2'd1:    return STEP_FWD;
      2'd2:    return STEP_ERR;
      2'd3:    return STEP_REV;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder pin: 2-FF synchroniser followed by a stability filter.
// After reset the first synchronised value is loaded directly and ready rises.
module quad_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic ready
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          fill1_reg;
  logic          fill2_reg;
  logic          filt_reg;
  logic          ready_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      fill1_reg <= 1'b0;
      fill2_reg <= 1'b0;
      filt_reg  <= 1'b0;
      ready_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      fill1_reg <= 1'b1;
      fill2_reg <= fill1_reg;
      // fill2_reg marks the first cycle the synchroniser holds a real pin sample
      if (!ready_reg) begin
        if (fill2_reg) begin
          filt_reg  <= sync2_reg;
          ready_reg <= 1'b1;
        end
        cnt_reg <= '0;
      end else if (sync2_reg != filt_reg) begin
        if (cnt_reg == CW'(FILT_LEN - 1)) begin
          filt_reg <= sync2_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign filt  = filt_reg;
  assign ready = ready_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder receiver: filtered A/B pins, 4x decode into a wrapping
// position, windowed velocity, sticky illegal-transition flag, Avalon-MM regs.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 4,
  parameter int VEL_PERIOD = 50000,
  parameter int VEL_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam int WIN_W = $clog2(VEL_PERIOD);
  localparam logic signed [VEL_W-1:0] VEL_MAX = VEL_W'((longint'(1) << (VEL_W - 1)) - 1);
  localparam logic signed [VEL_W-1:0] VEL_MIN = -VEL_MAX;

  logic [1:0] pins;
  logic [1:0] filt_ab;
  logic [1:0] ready_ab;

  assign pins = {enc_a, enc_b};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    quad_filter #(.FILT_LEN(FILT_LEN)) u_filter (
      .clk   (clk),
      .reset (reset),
      .pin   (pins[gi]),
      .filt  (filt_ab[gi]),
      .ready (ready_ab[gi])
    );
  end

  logic [1:0]              prev_reg;
  logic                    valid_reg;
  logic [CNT_W-1:0]        pos_reg;
  logic                    dir_reg;
  logic                    err_reg;
  logic signed [VEL_W-1:0] acc_reg;
  logic signed [VEL_W-1:0] acc_next;
  logic signed [VEL_W-1:0] vel_reg;
  logic [WIN_W-1:0]        win_reg;
  logic [31:0]             rd_next;
  step_t                   step;
  logic                    win_last;
  logic                    preload_wr;
  logic                    err_clr;

  // No step until a previous state has been adopted after reset.
  assign step       = valid_reg ? decode_step(prev_reg, filt_ab) : STEP_NONE;
  assign win_last   = (win_reg == WIN_W'(VEL_PERIOD - 1));
  assign preload_wr = avs_write && (avs_address == ADDR_PRELOAD);
  assign err_clr    = avs_write && (avs_address == ADDR_STATUS) && avs_writedata[STATUS_ERR_BIT];

  always_comb begin
    acc_next = acc_reg;
    if (step == STEP_FWD && acc_reg != VEL_MAX) begin
      acc_next = acc_reg + VEL_W'(1);
    end else if (step == STEP_REV && acc_reg != VEL_MIN) begin
      acc_next = acc_reg - VEL_W'(1);
    end
  end

  always_comb begin
    rd_next = '0;
    case (avs_address)
      ADDR_POS:    rd_next = 32'($signed(pos_reg));
      ADDR_VEL:    rd_next = 32'(vel_reg);
      ADDR_STATUS: begin
        rd_next[STATUS_ERR_BIT] = err_reg;
        rd_next[STATUS_DIR_BIT] = dir_reg;
      end
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg     <= '0;
      valid_reg    <= 1'b0;
      pos_reg      <= '0;
      dir_reg      <= 1'b0;
      err_reg      <= 1'b0;
      acc_reg      <= '0;
      vel_reg      <= '0;
      win_reg      <= '0;
      avs_readdata <= '0;
    end else begin
      prev_reg  <= filt_ab;
      valid_reg <= valid_reg | (&ready_ab);

      if (preload_wr) begin
        pos_reg <= avs_writedata[CNT_W-1:0];
      end else if (step == STEP_FWD) begin
        pos_reg <= pos_reg + CNT_W'(1);
      end else if (step == STEP_REV) begin
        pos_reg <= pos_reg - CNT_W'(1);
      end

      if (step == STEP_FWD) begin
        dir_reg <= 1'b1;
      end else if (step == STEP_REV) begin
        dir_reg <= 1'b0;
      end

      if (step == STEP_ERR) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end

      // The last window cycle's step lands in VEL, not in the next window.
      if (win_last) begin
        vel_reg <= acc_next;
        acc_reg <= '0;
        win_reg <= '0;
      end else begin
        acc_reg <= acc_next;
        win_reg <= win_reg + WIN_W'(1);
      end

      if (avs_read) begin
        avs_readdata <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a pin-history model predicts every read,
// literal register reads pin the model on the scenarios of interest.
module tb_quad_decoder;

  localparam int F    = 4;
  localparam int P    = 100;
  localparam int HMAX = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  quad_decoder #(.CNT_W(32), .FILT_LEN(F), .VEL_PERIOD(P), .VEL_W(16)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rd1)
  );

  quad_decoder #(.CNT_W(32), .FILT_LEN(F), .VEL_PERIOD(P), .VEL_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rd2)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          ha [HMAX];
  bit          hb [HMAX];
  int          n;
  bit          m_fa, m_fb, m_ready, m_valid;
  bit [1:0]    m_prev;
  logic [31:0] m_pos;
  bit          m_err, m_dir;
  int          m_acc1, m_acc2, m_vel1, m_vel2;
  logic [31:0] exp1 = 32'd0;
  logic [31:0] exp2 = 32'd0;
  int          ring [4] = '{0, 3, 1, 2};

  function automatic int clamp(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic [31:0] reg_view(input logic [1:0] a, input int vel);
    case (a)
      2'd0:    return m_pos;
      2'd1:    return vel;
      2'd2:    return {30'd0, m_dir, m_err};
      default: return 32'd0;
    endcase
  endfunction

  // A filtered bit flips once the F samples taken at edges n-1-F .. n-2 all oppose it.
  function automatic bit settled(input bit f, input bit is_a);
    if (n - 1 - F < 2 || n - 2 >= HMAX) return f;
    for (int j = n - 1 - F; j <= n - 2; j++) begin
      if ((is_a ? ha[j] : hb[j]) == f) return f;
    end
    return !f;
  endfunction

  always @(posedge clk) begin
    int d;
    bit ill;
    bit [1:0] cur;
    if (reset) begin
      n = 0; m_fa = 0; m_fb = 0; m_ready = 0; m_valid = 0; m_prev = 2'b00;
      m_pos = 32'd0; m_err = 0; m_dir = 0;
      m_acc1 = 0; m_acc2 = 0; m_vel1 = 0; m_vel2 = 0;
      exp1 = 32'd0; exp2 = 32'd0;
    end else begin
      if (avs_read) begin
        exp1 = reg_view(avs_address, m_vel1);
        exp2 = reg_view(avs_address, m_vel2);
      end
      d = 0; ill = 0; cur = {m_fa, m_fb};
      if (m_valid && cur != m_prev) begin
        case ((ring[cur] - ring[m_prev] + 4) % 4)
          1:       d = 1;
          3:       d = -1;
          default: ill = 1;
        endcase
      end
      m_valid = m_valid | m_ready;
      m_prev  = cur;
      if (avs_write && avs_address == 2'd3) m_pos = avs_writedata;
      else m_pos = m_pos + 32'(d);
      if (d > 0) m_dir = 1; else if (d < 0) m_dir = 0;
      if (ill) m_err = 1;
      else if (avs_write && avs_address == 2'd2 && avs_writedata[0]) m_err = 0;
      m_acc1 = clamp(m_acc1 + d, 32767);
      m_acc2 = clamp(m_acc2 + d, 7);
      n = n + 1;
      if (n % P == 0) begin
        m_vel1 = m_acc1; m_vel2 = m_acc2; m_acc1 = 0; m_acc2 = 0;
      end
      if (n < HMAX) begin
        ha[n] = enc_a; hb[n] = enc_b;
      end
      if (n == 3) begin
        m_fa = ha[1]; m_fb = hb[1]; m_ready = 1;
      end else if (m_ready) begin
        m_fa = settled(m_fa, 1'b1);
        m_fb = settled(m_fb, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    checks = checks + 2;
    if (rd1 !== exp1) begin
      errors++;
      $display("FAIL model_rd16 t=%0t got %h want %h", $time, rd1, exp1);
    end
    if (rd2 !== exp2) begin
      errors++;
      $display("FAIL model_rd4 t=%0t got %h want %h", $time, rd2, exp2);
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] seq [4];
  int ph = 0;

  task automatic set_pins(input int p);
    ph = p;
    {enc_a, enc_b} = seq[ph];
  endtask

  task automatic step(input bit fwd);
    set_pins(fwd ? (ph + 1) % 4 : (ph + 3) % 4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("RESET released t=%0t pins=%b", $time, {enc_a, enc_b});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    $display("WR addr=%0d data=%h", a, d);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] e1, input logic [31:0] e2,
                        input string nm);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    checks = checks + 2;
    if (rd1 !== e1) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd1, e1);
    end
    if (rd2 !== e2) begin
      errors++;
      $display("FAIL %s_w4 got %h want %h", nm, rd2, e2);
    end
    $display("RD %s addr=%0d data=%h/%h", nm, a, rd1, rd2);
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    @(negedge clk);

    // Velocity: 10 forward edges inside the first window, then an idle window.
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      repeat (7) @(negedge clk);
    end
    repeat (26) @(negedge clk);
    rd_chk(2'd1, 32'd10, 32'd7, "vel_window");
    rd_chk(2'd0, 32'd10, 32'd10, "pos_after_vel");
    rd_chk(2'd2, 32'h2, 32'h2, "status_fwd");
    repeat (97) @(negedge clk);
    rd_chk(2'd1, 32'd0, 32'd0, "vel_idle");

    // 8 full forward cycles.
    set_pins(0);
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      repeat (10) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rd_chk(2'd0, 32'd32, 32'd32, "pos_32");
    rd_chk(2'd2, 32'h2, 32'h2, "status_32");

    // 5 reverse edges from zero.
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      repeat (10) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rd_chk(2'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, "pos_rev5");
    rd_chk(2'd2, 32'h0, 32'h0, "status_rev");

    // Glitch filter: 3-clock pulse rejected, 4-clock pulse accepted at k+6.
    set_pins(0);
    do_reset();
    repeat (10) @(negedge clk);
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (15) @(negedge clk);
    rd_chk(2'd0, 32'd0, 32'd0, "pos_pulse3");
    enc_a = 1'b1; avs_address = 2'd0; avs_read = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) enc_a = 1'b0;
      if (i == 7 || i == 8) begin
        checks++;
        if (rd1 !== ((i == 8) ? 32'd1 : 32'd0)) begin
          errors++;
          $display("FAIL pulse4_k%0d got %h want %h", i - 2, rd1, (i == 8) ? 32'd1 : 32'd0);
        end
        $display("RD pulse4_k%0d data=%h", i - 2, rd1);
      end
    end
    avs_read = 1'b0;
    repeat (20) @(negedge clk);

    // Illegal jumps, ERR clear, ignored writes, set-beats-clear.
    set_pins(2);
    repeat (12) @(negedge clk);
    rd_chk(2'd0, 32'd0, 32'd0, "pos_illegal");
    rd_chk(2'd2, 32'h1, 32'h1, "status_err");
    wr(2'd0, 32'hDEAD_BEEF);
    wr(2'd1, 32'h0000_0055);
    wr(2'd2, 32'h0000_0002);
    rd_chk(2'd2, 32'h1, 32'h1, "status_ignored_wr");
    rd_chk(2'd0, 32'd0, 32'd0, "pos_ignored_wr");
    wr(2'd2, 32'h1);
    rd_chk(2'd2, 32'h0, 32'h0, "status_cleared");
    set_pins(0);
    repeat (6) @(negedge clk);
    wr(2'd2, 32'h1);
    rd_chk(2'd2, 32'h1, 32'h1, "status_set_wins");

    // Preload coincident with a forward step.
    step(1'b1);
    repeat (6) @(negedge clk);
    wr(2'd3, 32'h0000_1000);
    rd_chk(2'd0, 32'h1000, 32'h1000, "pos_preload");
    rd_chk(2'd3, 32'h0, 32'h0, "preload_reads0");

    // Reset mid-motion with pins settling at 11.
    step(1'b1);
    repeat (3) @(negedge clk);
    do_reset();
    rd_chk(2'd0, 32'h0, 32'h0, "rst_pos");
    rd_chk(2'd1, 32'h0, 32'h0, "rst_vel");
    rd_chk(2'd2, 32'h0, 32'h0, "rst_status");
    rd_chk(2'd3, 32'h0, 32'h0, "rst_preload");
    repeat (20) @(negedge clk);
    rd_chk(2'd2, 32'h0, 32'h0, "adopt_status");
    rd_chk(2'd0, 32'h0, 32'h0, "adopt_pos");
    step(1'b1);
    repeat (12) @(negedge clk);
    rd_chk(2'd0, 32'd1, 32'd1, "pos_after_adopt");
    rd_chk(2'd2, 32'h2, 32'h2, "status_after_adopt");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
